// File: rtl/alarm_ring_ctrl_if.sv
// Alarm sequencer bus: arming/trigger/button inputs and the ring status outputs.
interface alarm_ring_ctrl_if;
    logic        alarm_set;
    logic        alarm_trigger;
    logic        snooze_btn;
    logic        stop_btn;
    logic        buzzer_on;
    logic        snoozing;
    logic [1:0]  ring_state;
    logic [3:0]  snooze_count;
    logic [15:0] remaining_secs;
    logic        missed_alarm;

    modport master (
        output alarm_set, alarm_trigger, snooze_btn, stop_btn,
        input  buzzer_on, snoozing, ring_state, snooze_count, remaining_secs, missed_alarm
    );

    modport slave (
        input  alarm_set, alarm_trigger, snooze_btn, stop_btn,
        output buzzer_on, snoozing, ring_state, snooze_count, remaining_secs, missed_alarm
    );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: rings on a rising match flag, handles snooze/stop,
// caps snoozes per event and flags a ring period that timed out unanswered.
module alarm_ring_ctrl #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SECS  = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic              clk_1hz,
    input  logic              reset,
    alarm_ring_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam logic [15:0] RING_LOAD   = 16'(RING_TIMEOUT - 1);
    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_SECS - 1);
    localparam logic [3:0]  SNZ_MAX     = 4'(MAX_SNOOZE);

    state_t      state_q, state_d;
    logic        trig_q, trig_d;
    logic        buzzer_q, buzzer_d;
    logic        snoozing_q, snoozing_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rem_q, rem_d;
    logic        missed_q, missed_d;
    logic        start;

    // Only the rising edge of the match flag starts an event; a held flag does not.
    assign start = bus.alarm_trigger & ~trig_q;

    always_comb begin
        state_d  = state_q;
        trig_d   = bus.alarm_trigger;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        missed_d = missed_q;
        case (state_q)
            IDLE: begin
                rem_d = '0;
                if (bus.stop_btn) missed_d = 1'b0;
                if (start && bus.alarm_set) begin
                    state_d = RINGING;
                    rem_d   = RING_LOAD;
                    cnt_d   = '0;
                end
            end
            RINGING: begin
                if (!bus.alarm_set) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (bus.stop_btn) begin
                    state_d  = IDLE;
                    rem_d    = '0;
                    missed_d = 1'b0;
                end else if (bus.snooze_btn && cnt_q < SNZ_MAX) begin
                    state_d = SNOOZE;
                    rem_d   = SNOOZE_LOAD;
                    cnt_d   = cnt_q + 4'd1;
                end else if (rem_q == '0) begin
                    state_d  = IDLE;
                    missed_d = 1'b1;
                end else begin
                    rem_d = rem_q - 16'd1;
                end
            end
            SNOOZE: begin
                if (!bus.alarm_set) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (bus.stop_btn) begin
                    state_d  = IDLE;
                    rem_d    = '0;
                    missed_d = 1'b0;
                end else if (rem_q == '0) begin
                    state_d = RINGING;
                    rem_d   = RING_LOAD;
                end else begin
                    rem_d = rem_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
        buzzer_d   = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            buzzer_q   <= 1'b0;
            snoozing_q <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            buzzer_q   <= buzzer_d;
            snoozing_q <= snoozing_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            missed_q   <= missed_d;
        end
    end

    assign bus.buzzer_on      = buzzer_q;
    assign bus.snoozing       = snoozing_q;
    assign bus.ring_state     = state_q;
    assign bus.snooze_count   = cnt_q;
    assign bus.remaining_secs = rem_q;
    assign bus.missed_alarm   = missed_q;
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with RING_TIMEOUT=5, SNOOZE_SECS=4, MAX_SNOOZE=2.
module tb_alarm_ring_ctrl;
    logic clk_1hz = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [3:0]  cnt;
        logic [15:0] rem;
        logic        missed;
    } exp_t;

    exp_t sb[$];

    alarm_ring_ctrl_if bus();

    alarm_ring_ctrl #(
        .RING_TIMEOUT (5),
        .SNOOZE_SECS  (4),
        .MAX_SNOOZE   (2)
    ) dut (
        .clk_1hz (clk_1hz),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "/state"},    16'(bus.ring_state),     16'(e.st));
            chk({e.tag, "/buzzer"},   16'(bus.buzzer_on),      16'(e.st == 2'd1));
            chk({e.tag, "/snoozing"}, 16'(bus.snoozing),       16'(e.st == 2'd2));
            chk({e.tag, "/count"},    16'(bus.snooze_count),   16'(e.cnt));
            chk({e.tag, "/remain"},   bus.remaining_secs,      e.rem);
            chk({e.tag, "/missed"},   16'(bus.missed_alarm),   16'(e.missed));
        end
    endtask

    // Drive one cycle of inputs, record the expected post-edge outputs, then check them.
    task automatic cyc(input logic set, input logic trig, input logic snz, input logic stp,
                       input string tag, input logic [1:0] st, input logic [3:0] cnt,
                       input logic [15:0] rem, input logic missed);
        exp_t e;
        bus.alarm_set     = set;
        bus.alarm_trigger = trig;
        bus.snooze_btn    = snz;
        bus.stop_btn      = stp;
        e = '{tag, st, cnt, rem, missed};
        sb.push_back(e);
        @(posedge clk_1hz);
        #1;
        check_out();
    endtask

    task automatic expect_now(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                              input logic [15:0] rem, input logic missed);
        exp_t e;
        e = '{tag, st, cnt, rem, missed};
        sb.push_back(e);
        check_out();
    endtask

    initial begin
        reset             = 1'b1;
        bus.alarm_set     = 1'b0;
        bus.alarm_trigger = 1'b0;
        bus.snooze_btn    = 1'b0;
        bus.stop_btn      = 1'b0;
        #2;
        expect_now("reset", 2'd0, 4'd0, 16'd0, 1'b0);
        @(posedge clk_1hz);
        #1;
        reset = 1'b0;

        // 1: unanswered ring times out, held trigger never re-rings, stop clears the flag
        cyc(1, 0, 0, 0, "t1_idle", 2'd0, 4'd0, 16'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 0, 0, "t1_ring", 2'd1, 4'd0, 16'(4 - i), 1'b0);
        cyc(1, 1, 0, 0, "t1_timeout", 2'd0, 4'd0, 16'd0, 1'b1);
        for (int i = 0; i < 54; i++)
            cyc(1, 1, 0, 0, "t1_hold", 2'd0, 4'd0, 16'd0, 1'b1);
        cyc(1, 0, 0, 0, "t1_trig_low", 2'd0, 4'd0, 16'd0, 1'b1);
        cyc(1, 0, 0, 1, "t1_stop", 2'd0, 4'd0, 16'd0, 1'b0);
        cyc(1, 0, 0, 0, "t1_after", 2'd0, 4'd0, 16'd0, 1'b0);

        // 2: snooze on the second ring cycle, snooze button held is ignored while snoozing
        cyc(1, 1, 0, 0, "t2_start", 2'd1, 4'd0, 16'd4, 1'b0);
        cyc(1, 1, 0, 0, "t2_r1", 2'd1, 4'd0, 16'd3, 1'b0);
        cyc(1, 1, 1, 0, "t2_snz", 2'd2, 4'd1, 16'd3, 1'b0);
        for (int i = 1; i < 4; i++)
            cyc(1, 1, 1, 0, "t2_snoozing", 2'd2, 4'd1, 16'(3 - i), 1'b0);
        cyc(1, 1, 0, 0, "t2_rering", 2'd1, 4'd1, 16'd4, 1'b0);

        // 3: second snooze reaches the limit, third request ignored, ring times out
        cyc(1, 1, 1, 0, "t3_snz2", 2'd2, 4'd2, 16'd3, 1'b0);
        for (int i = 1; i < 4; i++)
            cyc(1, 1, 0, 0, "t3_snoozing", 2'd2, 4'd2, 16'(3 - i), 1'b0);
        cyc(1, 1, 0, 0, "t3_rering", 2'd1, 4'd2, 16'd4, 1'b0);
        cyc(1, 1, 1, 0, "t3_ignored", 2'd1, 4'd2, 16'd3, 1'b0);
        for (int i = 1; i < 4; i++)
            cyc(1, 1, 0, 0, "t3_ring", 2'd1, 4'd2, 16'(3 - i), 1'b0);
        cyc(1, 1, 0, 0, "t3_timeout", 2'd0, 4'd2, 16'd0, 1'b1);

        // 4: stop wins over snooze; snooze count held, missed flag cleared
        cyc(1, 0, 0, 0, "t4_idle", 2'd0, 4'd2, 16'd0, 1'b1);
        cyc(1, 1, 0, 0, "t4_start", 2'd1, 4'd0, 16'd4, 1'b1);
        cyc(1, 1, 1, 0, "t4_snz", 2'd2, 4'd1, 16'd3, 1'b1);
        for (int i = 1; i < 4; i++)
            cyc(1, 1, 0, 0, "t4_snoozing", 2'd2, 4'd1, 16'(3 - i), 1'b1);
        cyc(1, 1, 0, 0, "t4_rering", 2'd1, 4'd1, 16'd4, 1'b1);
        cyc(1, 1, 1, 1, "t4_stop", 2'd0, 4'd1, 16'd0, 1'b0);

        // 5: disarm during snooze, and a trigger while disarmed never rings
        cyc(1, 0, 0, 0, "t5_idle", 2'd0, 4'd1, 16'd0, 1'b0);
        cyc(1, 1, 0, 0, "t5_start", 2'd1, 4'd0, 16'd4, 1'b0);
        cyc(1, 1, 1, 0, "t5_snz", 2'd2, 4'd1, 16'd3, 1'b0);
        cyc(0, 1, 0, 0, "t5_disarm", 2'd0, 4'd1, 16'd0, 1'b0);
        cyc(0, 0, 0, 0, "t5_low", 2'd0, 4'd1, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 0, "t5_trig_disarmed", 2'd0, 4'd1, 16'd0, 1'b0);
        cyc(1, 1, 0, 0, "t5_arm_held", 2'd0, 4'd1, 16'd0, 1'b0);

        // 6: async reset mid-ring clears outputs before any edge
        cyc(1, 0, 0, 0, "t6_idle", 2'd0, 4'd1, 16'd0, 1'b0);
        cyc(1, 1, 0, 0, "t6_start", 2'd1, 4'd0, 16'd4, 1'b0);
        cyc(1, 1, 0, 0, "t6_r1", 2'd1, 4'd0, 16'd3, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        expect_now("t6_async_reset", 2'd0, 4'd0, 16'd0, 1'b0);
        #1;
        reset = 1'b0;
        cyc(1, 1, 0, 0, "t6_restart", 2'd1, 4'd0, 16'd4, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
Sequences the user-facing alarm once the comparator raises its match flag. It drives the buzzer for a bounded ring period, handles snooze and stop buttons, limits the number of snoozes, and flags an unanswered alarm. It sits between the alarm compare block (alarm_trigger, alarm_set) and the buzzer and display logic, on the same 1 Hz clock as the clock core.

Parameters:
RING_TIMEOUT, 60, number of clk_1hz cycles the buzzer rings before auto-off (range 1..65535)
SNOOZE_SECS, 300, snooze duration in clk_1hz cycles (range 1..65535)
MAX_SNOOZE, 3, maximum snoozes per alarm event (range 0..15)

Ports:
clk_1hz  input  1  1 Hz system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
alarm_set  input  1  alarm armed; level input from the alarm compare block
alarm_trigger  input  1  match flag from the compare block; high for the whole matching minute
snooze_btn  input  1  debounced snooze request, sampled as a level each cycle
stop_btn  input  1  debounced stop request, sampled as a level each cycle
buzzer_on  output  1  registered; high while in RINGING
snoozing  output  1  registered; high while in SNOOZE
ring_state  output  2  current state: 0 IDLE, 1 RINGING, 2 SNOOZE
snooze_count  output  4  snoozes taken in the current alarm event
remaining_secs  output  16  countdown value for the current RINGING or SNOOZE period; 0 in IDLE
missed_alarm  output  1  sticky; set when a ring period times out without user action

Behaviour:
- Reset (async): state IDLE. buzzer_on, snoozing, snooze_count, remaining_secs, missed_alarm all 0. Internal trigger-delay register trig_q is 0.
- Edge detect: trig_q is updated to alarm_trigger every cycle. A start event is alarm_trigger=1 and trig_q=0 at a clock edge. The held-high trigger never restarts ringing.
- IDLE:
  - Start event with alarm_set=1 → RINGING at that same edge.
  - remaining_secs loads RING_TIMEOUT-1; snooze_count loads 0.
  - A start event with alarm_set=0 is ignored.
- RINGING, with priority from highest to lowest:
  1. alarm_set=0 → IDLE.
  2. stop_btn=1 → IDLE; clears missed_alarm.
  3. snooze_btn=1 and snooze_count<MAX_SNOOZE → SNOOZE; remaining_secs loads SNOOZE_SECS-1; snooze_count increments.
  4. remaining_secs=0 → IDLE; missed_alarm set to 1.
  5. Otherwise remaining_secs decrements.
  - snooze_btn with snooze_count=MAX_SNOOZE is ignored, so ringing continues and the timeout still applies.
  - Buzzer is high for exactly RING_TIMEOUT cycles if there is no user action.
- SNOOZE, with priority from highest to lowest:
  1. alarm_set=0 → IDLE.
  2. stop_btn=1 → IDLE; clears missed_alarm.
  3. remaining_secs=0 → RINGING; remaining_secs loads RING_TIMEOUT-1.
  4. Otherwise remaining_secs decrements.
  - snooze_btn is ignored in SNOOZE.
  - SNOOZE lasts exactly SNOOZE_SECS cycles.
- Start events while in RINGING or SNOOZE are ignored.
- stop_btn in IDLE clears missed_alarm; it has no other effect.
- Every transition to IDLE forces remaining_secs to 0. snooze_count holds its value until the next start event.
- Outputs are registered and change on the same edge as the state: buzzer_on = (state==RINGING), snoozing = (state==SNOOZE).
- Illegal state value 3 → IDLE on the next edge.
- Reset asserted mid-ring or mid-snooze → immediately all outputs 0 and state IDLE.
- No arithmetic wrap:
  - Decrement happens only when remaining_secs > 0.
  - snooze_count never exceeds MAX_SNOOZE.

Test Plan:
Params used: RING_TIMEOUT=5, SNOOZE_SECS=4, MAX_SNOOZE=2.
1. Ring timeout: alarm_set=1, alarm_trigger rises and holds high for 60 cycles, no buttons → buzzer_on high for exactly 5 cycles, then IDLE. missed_alarm=1 and no re-ring while the trigger stays high. A later stop_btn pulse clears missed_alarm.
2. Snooze cycle: trigger, snooze_btn at ring cycle 2 → snoozing high for 4 cycles with remaining_secs counting 3,2,1,0, then buzzer_on again with remaining_secs=4 and snooze_count=1.
3. Snooze limit: snooze twice (snooze_count=2), then snooze_btn in the third ring → ignored. buzzer_on stays high until timeout; snooze_count stays 2.
4. Stop priority: snooze_btn and stop_btn both high during RINGING → IDLE. snooze_count unchanged; missed_alarm=0.
5. Disarm: alarm_set dropped in SNOOZE → IDLE next edge. A trigger with alarm_set=0 never asserts buzzer_on.
6. Async reset: assert reset mid-RINGING between clock edges → buzzer_on=0, ring_state=0 and remaining_secs=0 without waiting for a clock edge.
